// File: rtl/mux_scan_seq_if.sv
// Bundle of the scan sequencer's control, status and mux-facing signals.
// The master side drives requests and the mux return path; the sequencer is the slave.
interface mux_scan_seq_if #(
  parameter int DATA_W = 4
);
  logic              start;
  logic              stop;
  logic              cont;
  logic [7:0]        mask;
  logic [DATA_W-1:0] mux_out;
  logic [2:0]        sel;
  logic              busy;
  logic [DATA_W-1:0] data_out;
  logic [2:0]        ch_out;
  logic              valid;
  logic              done;

  modport master (
    output start, stop, cont, mask, mux_out,
    input  sel, busy, data_out, ch_out, valid, done
  );

  modport slave (
    input  start, stop, cont, mask, mux_out,
    output sel, busy, data_out, ch_out, valid, done
  );
endinterface

// File: rtl/mux_scan_seq.sv
// Channel scan sequencer for an 8:1 mux: walks enabled channels in ascending order,
// dwells DWELL cycles on each and emits the captured sample as a one-cycle valid beat.
module mux_scan_seq #(
  parameter int DATA_W = 4,
  parameter int DWELL  = 4
) (
  input  logic          clk,
  input  logic          rst,
  mux_scan_seq_if.slave bus
);

  localparam logic [7:0] DLAST = 8'(DWELL - 1);

  typedef enum logic {S_IDLE, S_SCAN} state_e;

  state_e            state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic [7:0]        dcnt_q, dcnt_d;
  logic [7:0]        mask_q, mask_d;
  logic              cont_q, cont_d;
  logic              stop_pend_q, stop_pend_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [2:0]        ch_q, ch_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic [3:0] first_ch, next_ch, wrap_ch;
  logic       have_next;
  logic [2:0] next_sel;

  // Returns {found, index} of the lowest set bit of m.
  function automatic logic [3:0] lowest_set(input logic [7:0] m);
    lowest_set = 4'b0;
    for (int k = 7; k >= 0; k--) begin
      if (m[k]) lowest_set = {1'b1, 3'(k)};
    end
  endfunction

  // Returns {found, index} of the lowest set bit of m strictly above s.
  function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] s);
    next_above = 4'b0;
    for (int k = 7; k >= 0; k--) begin
      if (m[k] && (k > int'(s))) next_above = {1'b1, 3'(k)};
    end
  endfunction

  assign first_ch  = lowest_set(bus.mask);
  assign next_ch   = next_above(mask_q, sel_q);
  assign wrap_ch   = lowest_set(mask_q);
  assign have_next = next_ch[3] | (cont_q & wrap_ch[3]);
  assign next_sel  = next_ch[3] ? next_ch[2:0] : wrap_ch[2:0];

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    dcnt_d      = dcnt_q;
    mask_d      = mask_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q;
    data_d      = data_q;
    ch_d        = ch_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.mask != 8'h00) begin
            mask_d      = bus.mask;
            cont_d      = bus.cont;
            sel_d       = first_ch[2:0];
            dcnt_d      = 8'd0;
            stop_pend_d = 1'b0;
            state_d     = S_SCAN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_SCAN: begin
        if (bus.stop) stop_pend_d = 1'b1;
        if (dcnt_q != DLAST) begin
          dcnt_d = dcnt_q + 8'd1;
        end else begin
          // Capture cycle: the current channel always finishes before a stop takes effect.
          data_d  = bus.mux_out;
          ch_d    = sel_q;
          valid_d = 1'b1;
          if (have_next && !stop_pend_q && !bus.stop) begin
            sel_d  = next_sel;
            dcnt_d = 8'd0;
          end else begin
            state_d     = S_IDLE;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sel_q       <= 3'd0;
      dcnt_q      <= 8'd0;
      mask_q      <= 8'h00;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      data_q      <= '0;
      ch_q        <= 3'd0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      dcnt_q      <= dcnt_d;
      mask_q      <= mask_d;
      cont_q      <= cont_d;
      stop_pend_q <= stop_pend_d;
      data_q      <= data_d;
      ch_q        <= ch_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  assign bus.sel      = sel_q;
  assign bus.busy     = (state_q == S_SCAN);
  assign bus.data_out = data_q;
  assign bus.ch_out   = ch_q;
  assign bus.valid    = valid_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq: two instances (DWELL=4 and DWELL=1) checked every cycle
// against a timeline model built from the channel list, dwell and stop time.
module tb_mux_scan_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_scan_seq_if #(.DATA_W(4)) ifa ();
  mux_scan_seq_if #(.DATA_W(4)) ifb ();

  mux_scan_seq #(.DATA_W(4), .DWELL(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  mux_scan_seq #(.DATA_W(4), .DWELL(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  logic       start, stop, cont, use_b;
  logic [7:0] mask;
  logic [3:0] tab [8];

  assign ifa.start   = start & ~use_b;
  assign ifa.stop    = stop & ~use_b;
  assign ifa.cont    = cont;
  assign ifa.mask    = mask;
  assign ifa.mux_out = tab[ifa.sel];
  assign ifb.start   = start & use_b;
  assign ifb.stop    = stop & use_b;
  assign ifb.cont    = cont;
  assign ifb.mask    = mask;
  assign ifb.mux_out = tab[ifb.sel];

  logic [2:0] o_sel, o_ch;
  logic [3:0] o_dat;
  logic       o_busy, o_valid, o_done;
  assign o_sel   = use_b ? ifb.sel      : ifa.sel;
  assign o_ch    = use_b ? ifb.ch_out   : ifa.ch_out;
  assign o_dat   = use_b ? ifb.data_out : ifa.data_out;
  assign o_busy  = use_b ? ifb.busy     : ifa.busy;
  assign o_valid = use_b ? ifb.valid    : ifa.valid;
  assign o_done  = use_b ? ifb.done     : ifa.done;

  int n_tests = 0;
  int n_fail  = 0;
  int held_sel [2];
  int held_ch  [2];
  int held_dat [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int sel, input int ch, input int dat,
                         input int busy, input int valid, input int done);
    chk({tag, " sel"},   32'(o_sel),   32'(sel));
    chk({tag, " ch"},    32'(o_ch),    32'(ch));
    chk({tag, " data"},  32'(o_dat),   32'(dat));
    chk({tag, " busy"},  32'(o_busy),  32'(busy));
    chk({tag, " valid"}, 32'(o_valid), 32'(valid));
    chk({tag, " done"},  32'(o_done),  32'(done));
  endtask

  // stop_rel: -1 none, 0 together with start, k>=1 stop high in cycle T+k.
  // start_rel: 0 none, k>=1 extra start pulse in cycle T+k (must fall while busy).
  task automatic run_scan(input string name, input logic b, input logic [7:0] m,
                          input logic c, input int stop_rel, input int start_rel);
    int d, L, ns, n_tot, idx, beat, e_sel, e_valid;
    int base[$];
    int seq[$];
    use_b = b;
    d = b ? 1 : 4;
    for (int k = 0; k < 8; k++) if (m[k]) base.push_back(k);
    L = base.size();
    if (L == 0) n_tot = 0;
    else if (stop_rel >= 1) begin
      ns = (stop_rel + d - 1) / d;
      n_tot = c ? ns : ((ns < L) ? ns : L);
    end else n_tot = L;
    while (seq.size() < n_tot) foreach (base[i]) seq.push_back(base[i]);
    mask  = m;
    cont  = c;
    start = 1'b1;
    stop  = (stop_rel == 0);
    for (int k = 1; k <= n_tot * d + 2; k++) begin
      step();
      start = (k == start_rel);
      stop  = (k == stop_rel);
      mask  = 8'($urandom);
      cont  = 1'($urandom);
      beat = (k - 1) / d - 1;
      e_valid = ((k - 1) % d == 0 && beat >= 0 && beat < n_tot) ? 1 : 0;
      if (e_valid != 0) begin
        held_ch[b]  = seq[beat];
        held_dat[b] = int'(tab[seq[beat]]);
      end
      if (n_tot == 0) e_sel = held_sel[b];
      else begin
        idx = (k - 1) / d;
        if (idx >= n_tot) idx = n_tot - 1;
        e_sel = seq[idx];
      end
      chk_all($sformatf("%s k=%0d", name, k), e_sel, held_ch[b], held_dat[b],
              (k <= n_tot * d) ? 1 : 0, e_valid, (k == n_tot * d + 1) ? 1 : 0);
    end
    if (n_tot > 0) held_sel[b] = seq[n_tot - 1];
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    logic [7:0] rm;
    logic       rc, rb;
    int         rl, rs, rd;
    start = 1'b0; stop = 1'b0; cont = 1'b0; use_b = 1'b0; mask = 8'h00;
    for (int k = 0; k < 8; k++) tab[k] = 4'(k + 1);
    for (int i = 0; i < 2; i++) begin held_sel[i] = 0; held_ch[i] = 0; held_dat[i] = 0; end
    step();
    step();
    chk_all("reset A", 0, 0, 0, 0, 0, 0);
    use_b = 1'b1;
    chk_all("reset B", 0, 0, 0, 0, 0, 0);
    use_b = 1'b0;
    rst = 1'b0;
    step();

    run_scan("full", 1'b0, 8'hFF, 1'b0, -1, 0);
    for (int k = 0; k < 8; k++) tab[k] = 4'($urandom);
    run_scan("sparse", 1'b0, 8'b1010_0100, 1'b0, -1, 0);
    run_scan("empty", 1'b0, 8'h00, 1'b0, -1, 0);
    run_scan("cont_stop", 1'b0, 8'h81, 1'b1, 14, 0);
    run_scan("cont_single", 1'b0, 8'h10, 1'b1, 11, 0);
    run_scan("start_ignored", 1'b0, 8'h5A, 1'b0, -1, 6);
    run_scan("start_with_stop", 1'b0, 8'h12, 1'b0, 0, 0);
    run_scan("stop_at_capture", 1'b0, 8'h0E, 1'b0, 8, 0);

    // Abort a continuous scan mid-dwell.
    use_b = 1'b0; mask = 8'h3C; cont = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin held_sel[i] = 0; held_ch[i] = 0; held_dat[i] = 0; end
    chk_all("rst_abort", 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all($sformatf("after_rst %0d", k), 0, 0, 0, 0, 0, 0);
    end
    run_scan("post_rst", 1'b0, 8'h66, 1'b0, -1, 0);

    run_scan("dwell1", 1'b1, 8'h0F, 1'b0, -1, 0);
    run_scan("dwell1_cont", 1'b1, 8'h24, 1'b1, 5, 0);

    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < 8; k++) tab[k] = 4'($urandom);
      rm = 8'($urandom);
      rc = 1'($urandom);
      rb = 1'($urandom);
      rd = rb ? 1 : 4;
      rl = $countones(rm);
      if (rc) rs = int'($urandom_range(1, 2 * rl * rd + 1));
      else if ($urandom_range(0, 1) == 1) rs = int'($urandom_range(0, rl * rd));
      else rs = -1;
      run_scan($sformatf("rand%0d", it), rb, rm, rc, rs, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
